// File: rtl/attn_pkg.sv
// Shared definitions for the attention job sequencer.
//   seq_state_e   : sequencer FSM states
//   ST_*          : completion status codes reported on done_status
//   RELAUNCH_WAIT : WAIT_BUSY cycles with the engine still idle before relaunching
package attn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    REPORT,
    DRAIN
  } seq_state_e;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_TMO   = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  localparam int RELAUNCH_WAIT = 4;

endpackage

// File: rtl/job_fifo.sv
// Synchronous job-ID FIFO with a registered head entry.
//   clk, reset_n : clock, synchronous active-low reset
//   push, din    : write din when not full
//   pop          : drop the head entry when not empty
//   head         : oldest entry (valid while !empty)
//   full, empty  : occupancy flags
module job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_next = rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Head tracks the next-oldest entry; a push into an empty (or
      // emptying) queue bypasses storage straight into the head.
      if (do_pop) begin
        if (count > CNT_ONE) head <= mem[rd_next];
        else if (do_push)    head <= din;
      end else if (do_push && empty) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/attn_job_sequencer.sv
// Launches queued self-attention jobs one at a time on the QKV/score engine,
// times each job, enforces an optional timeout and returns one completion
// record per job.
//   clk, reset_n            : clock, synchronous active-low reset
//   job_valid/ready/id      : host job submission into the queue
//   eng_valid, eng_ready    : engine dut_valid / dut_ready (ready = engine idle)
//   tmo_limit               : cycle limit for a job, 0 = no timeout
//   abort                   : kill the running job
//   done_valid/ready/id/status/cycles : completion record handshake
//   busy                    : job running or queue non-empty
//
// state     | meaning
// IDLE      | waiting for a queued job, idle engine and no pending record
// LAUNCH    | eng_valid pulse for one cycle
// WAIT_BUSY | waiting for the engine to accept (ready low); relaunch if ignored
// WAIT_DONE | job running; watch completion, timeout, abort
// REPORT    | load the completion record
// DRAIN     | after TIMEOUT/ABORT, wait for the engine to return idle
module attn_job_sequencer
  import attn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 4,
  parameter int TMO_W      = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            job_valid,
  output logic            job_ready,
  input  logic [ID_W-1:0] job_id,
  output logic            eng_valid,
  input  logic            eng_ready,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic            abort,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [ID_W-1:0] done_id,
  output logic [1:0]      done_status,
  output logic [31:0]     done_cycles,
  output logic            busy
);

  localparam int WC_W = $clog2(RELAUNCH_WAIT);

  seq_state_e      state;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [ID_W-1:0] head;
  logic [ID_W-1:0] cur_id;
  logic [31:0]     cyc_cnt;
  logic [31:0]     cyc_next;
  logic [31:0]     res_cycles;
  logic [1:0]      res_status;
  logic [WC_W-1:0] wait_cnt;
  logic            tmo_hit;

  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign pop       = (state == IDLE) && !empty && eng_ready && !done_valid;
  assign busy      = (state != IDLE) || !empty;
  assign cyc_next  = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
  // >= so a limit already passed during LAUNCH/WAIT_BUSY still fires
  assign tmo_hit   = (tmo_limit != '0) && (cyc_cnt >= 32'(tmo_limit));

  job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (job_id),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // cyc_cnt holds the 1-based cycle number since the first LAUNCH, so the
  // value seen in the final WAIT_DONE cycle is the inclusive job length.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_id      <= '0;
      cyc_cnt     <= '0;
      wait_cnt    <= '0;
      res_status  <= ST_OK;
      res_cycles  <= '0;
      eng_valid   <= 1'b0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_status <= ST_OK;
      done_cycles <= '0;
    end else begin
      eng_valid <= 1'b0;
      if (done_valid && done_ready) begin
        done_valid  <= 1'b0;
        done_id     <= '0;
        done_status <= ST_OK;
        done_cycles <= '0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            cur_id    <= head;
            cyc_cnt   <= 32'd1;
            eng_valid <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          cyc_cnt  <= cyc_next;
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          cyc_cnt <= cyc_next;
          if (abort) begin
            res_status <= ST_ABORT;
            res_cycles <= cyc_cnt;
            state      <= REPORT;
          end else if (!eng_ready) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == WC_W'(RELAUNCH_WAIT - 1)) begin
            eng_valid <= 1'b1;
            state     <= LAUNCH;
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
        end
        WAIT_DONE: begin
          cyc_cnt <= cyc_next;
          if (abort || tmo_hit || eng_ready) begin
            res_status <= abort ? ST_ABORT : (tmo_hit ? ST_TMO : ST_OK);
            res_cycles <= cyc_cnt;
            state      <= REPORT;
          end
        end
        REPORT: begin
          done_valid  <= 1'b1;
          done_id     <= cur_id;
          done_status <= res_status;
          done_cycles <= res_cycles;
          state       <= DRAIN;
        end
        DRAIN: begin
          // A killed job may still be running in the engine.
          if (res_status == ST_OK || eng_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_job_sequencer.sv
module tb_attn_job_sequencer;

  logic        clk;
  logic        reset_n;
  logic        job_valid;
  logic        job_ready;
  logic [3:0]  job_id;
  logic        eng_valid;
  logic        eng_ready;
  logic [19:0] tmo_limit;
  logic        abort;
  logic        done_valid;
  logic        done_ready;
  logic [3:0]  done_id;
  logic [1:0]  done_status;
  logic [31:0] done_cycles;
  logic        busy;

  attn_job_sequencer #(.FIFO_DEPTH(4), .ID_W(4), .TMO_W(20)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_id      (job_id),
    .eng_valid   (eng_valid),
    .eng_ready   (eng_ready),
    .tmo_limit   (tmo_limit),
    .abort       (abort),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_id     (done_id),
    .done_status (done_status),
    .done_cycles (done_cycles),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int id;
    int status;
    int cycles;
  } rec_t;

  // One single-job scenario: engine keeps ready high until offset drop after
  // the first eng_valid, then low for run cycles; abort pulses at abort_at.
  typedef struct {
    int id;
    int tmo;
    int drop;
    int run;
    int abort_at;
    int status;
    int cycles;
    int launches;
  } vec_t;

  localparam int AE_RUN = 10;  // auto engine: busy from offset 2 for 10 cycles -> 13 cycles/job

  rec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   auto_eng = 0;
  bit   ae_active = 0;
  int   ae_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; completion records are scored on the way past.
  task automatic tick();
    rec_t e;
    @(negedge clk);
    if (reset_n && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record: got id=%0d status=%0d cycles=%0d expected none",
                 done_id, done_status, done_cycles);
      end else begin
        e = sb.pop_front();
        check("rec_id", 32'(done_id), e.id);
        check("rec_status", 32'(done_status), e.status);
        check("rec_cycles", done_cycles, e.cycles);
      end
    end
    @(posedge clk);
    #1;
    if (auto_eng) begin
      if (eng_valid) begin
        ae_active = 1;
        ae_t = 0;
      end else if (ae_active) begin
        ae_t++;
      end
      if (ae_active && ae_t >= 2 + AE_RUN) ae_active = 0;
      eng_ready = !(ae_active && ae_t >= 2);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int launches;
    int dv_t;
    bit fin;
    auto_eng = 0;
    tmo_limit = 20'(v.tmo);
    eng_ready = 1;
    abort = 0;
    done_ready = 1;
    job_valid = 1;
    job_id = 4'(v.id);
    tick();
    job_valid = 0;
    sb.push_back('{v.id, v.status, v.cycles});
    tick();
    check("launch_latency", 32'(eng_valid), 1);
    launches = 0;
    dv_t = -1;
    fin = 0;
    for (int t = 0; t < 800; t++) begin
      if (eng_valid) launches++;
      if (done_valid && dv_t < 0) dv_t = t;
      eng_ready = !(t >= v.drop && t < v.drop + v.run);
      abort = (v.abort_at != 0) && (t == v.abort_at);
      if (t >= v.drop + v.run && sb.size() == 0 && !busy) begin
        fin = 1;
        break;
      end
      tick();
    end
    abort = 0;
    eng_ready = 1;
    check("vec_finished", 32'(fin), 1);
    check("vec_launches", launches, v.launches);
    check("vec_done_valid_time", dv_t, v.cycles + 1);
  endtask

  vec_t vecs[10];
  int   launches;
  bit   got;

  initial begin
    vecs[0] = '{3,  0,   2,  50,  0,  0, 53, 1};
    vecs[1] = '{5,  0,   1,  1,   0,  0, 3,  1};
    vecs[2] = '{9,  100, 2,  300, 0,  1, 100, 1};
    vecs[3] = '{10, 30,  3,  10,  0,  0, 14, 1};
    vecs[4] = '{13, 14,  3,  10,  0,  1, 14, 1};  // timeout and completion together
    vecs[5] = '{1,  5,   2,  50,  0,  1, 5,  1};
    vecs[6] = '{6,  0,   2,  40,  20, 2, 21, 1};
    vecs[7] = '{7,  50,  2,  200, 49, 2, 50, 1};  // abort and timeout together
    vecs[8] = '{12, 0,   4,  20,  2,  2, 3,  1};  // abort in WAIT_BUSY
    vecs[9] = '{15, 0,   17, 5,   0,  0, 23, 4};  // three relaunches

    reset_n = 0;
    job_valid = 0;
    job_id = 0;
    eng_ready = 1;
    tmo_limit = 0;
    abort = 0;
    done_ready = 1;
    tick();
    tick();
    reset_n = 1;
    tick();
    check("rst_job_ready", 32'(job_ready), 1);
    check("rst_eng_valid", 32'(eng_valid), 0);
    check("rst_done_valid", 32'(done_valid), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_done_status", 32'(done_status), 0);
    check("rst_done_cycles", done_cycles, 0);
    check("rst_busy", 32'(busy), 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Fill the queue while the engine is busy, then re-offer the fifth ID.
    auto_eng = 0;
    tmo_limit = 0;
    eng_ready = 0;
    done_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      job_valid = 1;
      job_id = 4'(k);
      tick();
    end
    check("full_job_ready", 32'(job_ready), 0);
    job_id = 4'd5;
    tick();
    tick();
    tick();
    check("full_hold_job_ready", 32'(job_ready), 0);
    check("full_busy", 32'(busy), 1);
    for (int k = 1; k <= 5; k++) sb.push_back('{k, 0, 13});
    ae_active = 0;
    auto_eng = 1;
    eng_ready = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      got = job_ready;
      tick();
    end
    job_valid = 0;
    check("fifth_accepted", 32'(got), 1);
    wait_idle("five_jobs_drained", 600);

    // Timeout with the engine stuck: DRAIN must hold until the engine is idle.
    auto_eng = 0;
    tmo_limit = 100;
    eng_ready = 1;
    job_valid = 1;
    job_id = 4'd2;
    tick();
    job_valid = 0;
    sb.push_back('{2, 1, 100});
    tick();
    check("tmo_launch", 32'(eng_valid), 1);
    for (int t = 0; t < 300 && sb.size() != 0; t++) begin
      eng_ready = (t < 2);
      job_valid = (t == 10);
      job_id = 4'd4;
      tick();
    end
    job_valid = 0;
    check("tmo_record_taken", sb.size(), 0);
    eng_ready = 0;
    launches = 0;
    for (int i = 0; i < 10; i++) begin
      if (eng_valid) launches++;
      tick();
    end
    check("drain_hold_launches", launches, 0);
    check("drain_hold_busy", 32'(busy), 1);
    sb.push_back('{4, 0, 13});
    ae_active = 0;
    auto_eng = 1;
    eng_ready = 1;
    tick();
    check("drain_release_pop", 32'(eng_valid), 0);
    tick();
    check("drain_release_launch", 32'(eng_valid), 1);
    wait_idle("after_tmo_drained", 100);

    // Abort while idle produces nothing.
    auto_eng = 0;
    eng_ready = 1;
    abort = 1;
    tick();
    abort = 0;
    for (int i = 0; i < 4; i++) tick();
    check("idle_abort_no_record", 32'(done_valid), 0);
    check("idle_abort_busy", 32'(busy), 0);

    // Outstanding record blocks the next launch.
    tmo_limit = 0;
    ae_active = 0;
    auto_eng = 1;
    done_ready = 0;
    job_valid = 1;
    job_id = 4'd8;
    tick();
    job_id = 4'd11;
    tick();
    job_valid = 0;
    sb.push_back('{8, 0, 13});
    sb.push_back('{11, 0, 13});
    for (int i = 0; i < 100 && !done_valid; i++) tick();
    check("hold_dv_seen", 32'(done_valid), 1);
    launches = 0;
    for (int i = 0; i < 20; i++) begin
      if (eng_valid) launches++;
      tick();
    end
    check("hold_no_launch", launches, 0);
    check("hold_dv_still", 32'(done_valid), 1);
    check("hold_id", 32'(done_id), 8);
    done_ready = 1;
    tick();
    tick();
    check("hold_release_launch", 32'(eng_valid), 1);
    wait_idle("hold_drained", 100);

    // Reset in the middle of a job with another ID queued.
    auto_eng = 0;
    eng_ready = 1;
    job_valid = 1;
    job_id = 4'd14;
    tick();
    job_valid = 0;
    tick();
    check("rst_mid_launch", 32'(eng_valid), 1);
    eng_ready = 0;
    job_valid = 1;
    job_id = 4'd15;
    tick();
    job_valid = 0;
    tick();
    tick();
    reset_n = 0;
    tick();
    check("rst_mid_eng_valid", 32'(eng_valid), 0);
    check("rst_mid_done_valid", 32'(done_valid), 0);
    check("rst_mid_done_cycles", done_cycles, 0);
    check("rst_mid_job_ready", 32'(job_ready), 1);
    check("rst_mid_busy", 32'(busy), 0);
    reset_n = 1;
    eng_ready = 1;
    launches = 0;
    for (int i = 0; i < 10; i++) begin
      if (eng_valid) launches++;
      tick();
    end
    check("rst_mid_no_launch", launches, 0);
    check("rst_mid_no_record", 32'(done_valid), 0);
    check("sb_empty_at_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/attn_job_sequencer.md
# attn_job_sequencer

Sequences self-attention jobs onto the single QKV/score compute engine. Job IDs arrive from the host side through a small FIFO. The sequencer launches one job at a time over the engine's `dut_valid`/`dut_ready` handshake, then measures each job's cycle count and enforces a timeout. It returns one completion record per job through a valid/ready status port, and sits between host control and the engine's control pins.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — job queue entries; power of two, ≥2.
- `ID_W`, 4 — job ID width.
- `TMO_W`, 20 — timeout counter width.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `job_valid`  in  1  host offers a job.
- `job_ready`  out  1  queue not full.
- `job_id`  in  `ID_W`  ID of the offered job.
- `eng_valid`  out  1  drives engine `dut_valid`.
- `eng_ready`  in  1  from engine `dut_ready`; high means the engine is idle.
- `tmo_limit`  in  `TMO_W`  maximum cycles allowed in `WAIT_DONE`; 0 disables the timeout.
- `abort`  in  1  pulse; kills the running job with status ABORT.
- `done_valid`  out  1  a completion record is available.
- `done_ready`  in  1  the host accepts the record.
- `done_id`  out  `ID_W`  ID of the completed job.
- `done_status`  out  2  0=OK, 1=TIMEOUT, 2=ABORT.
- `done_cycles`  out  32  cycles from launch to completion.
- `busy`  out  1  state ≠ IDLE or queue non-empty.

## Operation
- FIFO push on `job_valid && job_ready`. Pop occurs in IDLE when the queue is non-empty, `eng_ready`=1 and `done_valid`=0.
- Push and pop in the same cycle are both honoured; the occupancy count is unchanged.
- States:
  - IDLE → LAUNCH on pop; the popped ID is latched into `cur_id`.
  - LAUNCH: `eng_valid`=1 for exactly this one cycle; cycle counter cleared to 1 → WAIT_BUSY.
  - WAIT_BUSY: `eng_ready`=0 → WAIT_DONE. If `eng_ready` stays 1 for 4 cycles → LAUNCH again (relaunch); the cycle counter keeps counting.
  - WAIT_DONE: `eng_ready`=1 → REPORT with status OK.
    - Counter reaches `tmo_limit` (when nonzero) → REPORT with TIMEOUT.
    - `abort` → REPORT with ABORT.
    - `abort` beats TIMEOUT, and both beat OK, when they occur in the same cycle.
  - REPORT: load the `done_*` registers and set `done_valid` → DRAIN.
  - DRAIN:
    - Status OK: go straight → IDLE.
    - Status TIMEOUT/ABORT: stay in DRAIN until `eng_ready`=1, i.e. the engine returns idle, then → IDLE.
- `done_valid` stays high until `done_ready`; the record is cleared on accept. IDLE will not pop while `done_valid`=1 (one outstanding record, no overwrite).
- `done_cycles` saturates at 0xFFFF_FFFF.
- `abort` outside WAIT_BUSY/WAIT_DONE is ignored.
- `abort` in WAIT_BUSY → REPORT with ABORT.

## Timing
- Reset values: `job_ready`=1, `eng_valid`=0, `done_valid`=0, `done_id`=0, `done_status`=0, `done_cycles`=0, `busy`=0. FIFO is empty, state is IDLE.
- All outputs are registered except `job_ready` (equals `!full`) and `busy`.
- Earliest launch: a push in cycle N, with the engine idle, gives pop in N+1 and `eng_valid` in N+2.
- `done_valid` rises 2 cycles after `eng_ready` rises in WAIT_DONE (REPORT, then the register update).
- `done_cycles` = cycles from LAUNCH through the last WAIT_DONE cycle, inclusive.
- A full FIFO deasserts `job_ready` in the same cycle. A push offered while full is dropped, and the host must hold it.
- Reset asserted mid-job clears everything next edge; no completion record is emitted for the in-flight job.

## Structure
- Shared package `attn_pkg`:
  - state enum `seq_state_e` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, REPORT, DRAIN)
  - status constants `ST_OK`, `ST_TMO`, `ST_ABORT`
  - `RELAUNCH_WAIT`=4
- Sub-module `job_fifo`: parameterised sync FIFO with `push`, `pop`, `full`, `empty` and a registered head.
- The FSM, counters and completion register live in the top.

## Test plan
- Single job, `tmo_limit`=0. Engine drops ready 2 cycles after `eng_valid` and raises it 50 cycles later → one `done_valid` with the job's ID, status 0 and the measured `done_cycles`.
- Push 5 IDs back-to-back with `FIFO_DEPTH`=4 → `job_ready` low after the 4th push, in-order completions once the 5th is re-offered, no ID lost or duplicated.
- `tmo_limit`=100 with the engine never finishing → status 1 and `done_cycles`=100. DRAIN holds until `eng_ready`=1, then the next job launches.
- `abort` and timeout in the same cycle → status 2.
- `abort` in IDLE → no record produced.
- Engine never drops ready → `eng_valid` re-pulsed every 5 cycles. Engine then goes busy and completes → exactly one record.
- `done_ready` held low for 20 cycles with 2 jobs queued → the second job is not launched until the first record is accepted.
- `reset_n` low during WAIT_DONE → all outputs at reset values next cycle; FIFO empty.
